// File: rtl/alu_matrix_apb_regs_if.sv
// APB3 bus bundle between the env master agent and the ALU matrix register file.
// The pstrb signal exists only when ALU_APB_PSTRB_EN is defined.
interface alu_matrix_apb_regs_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [ADDR_W-1:0]   paddr;
    logic [DATA_W-1:0]   pwdata;
`ifdef ALU_APB_PSTRB_EN
    logic [DATA_W/8-1:0] pstrb;
`endif
    logic [DATA_W-1:0]   prdata;
    logic                pready;
    logic                pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
`ifdef ALU_APB_PSTRB_EN
        output pstrb,
`endif
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
`ifdef ALU_APB_PSTRB_EN
        input  pstrb,
`endif
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/alu_matrix_apb_regs.sv
// APB3 completer register file for the ALU matrix core: CTRL/STATUS/IRQ/MAT_SIZE/ID
// registers, a registered one-cycle start pulse and W1C interrupt status driving irq_o.
// Optional feature macro: ALU_APB_PSTRB_EN (adds byte strobes on writes).
module alu_matrix_apb_regs #(
    parameter int          ADDR_W      = 12,
    parameter int          DATA_W      = 32,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'h00A1_0001
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_matrix_apb_regs_if.slave apb,
    output logic                 start_o,
    output logic [2:0]           op_o,
    output logic [7:0]           rows_o,
    output logic [7:0]           cols_o,
    input  logic                 busy_i,
    input  logic                 done_i,
    input  logic                 err_i,
    output logic                 irq_o
);
    typedef enum logic {S_IDLE, S_ACCESS} state_e;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                pready;
    logic [2:0]          idx;
    logic [DATA_W/8-1:0] strb;
    logic [DATA_W-1:0]   wmask;
    logic                addr_err, ro_err, start_req, err, wr_en;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          clr;

    logic       start_q, start_d;
    logic [2:0] op_q, op_d;
    logic [7:0] rows_q, rows_d, cols_q, cols_d;
    logic [1:0] irq_en_q, irq_en_d, irq_stat_q, irq_stat_d;
    logic       done_sticky_q, done_sticky_d;
    logic       irq_q, irq_d;

`ifdef ALU_APB_PSTRB_EN
    assign strb = apb.pstrb;
`else
    assign strb = '1;
`endif

    // Transfer FSM: enter ACCESS on setup, count wait states on penable, complete with pready.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        pready  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (apb.psel && !apb.penable) begin
                    state_d = S_ACCESS;
                    cnt_d   = '0;
                end
            end
            S_ACCESS: begin
                if (!apb.psel) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (apb.penable) begin
                    if (cnt_q == WS) begin
                        pready  = 1'b1;
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Address decode, error classification and byte-strobe expansion.
    always_comb begin
        idx       = apb.paddr[4:2];
        addr_err  = (|apb.paddr[ADDR_W-1:5]) || (|apb.paddr[1:0]) || (idx > 3'd5);
        ro_err    = apb.pwrite && (idx == 3'd1 || idx == 3'd5);
        start_req = apb.pwrite && (idx == 3'd0) && apb.pwdata[0] && strb[0];
        err       = addr_err || ro_err || (start_req && busy_i);
        wr_en     = pready && apb.pwrite && !err;
        wmask     = '0;
        for (int b = 0; b < DATA_W / 8; b++) begin
            wmask[b*8 +: 8] = {8{strb[b]}};
        end
    end

    // Register next-state: write commits, start pulse, sticky done and W1C status (set wins).
    always_comb begin
        op_d          = op_q;
        rows_d        = rows_q;
        cols_d        = cols_q;
        irq_en_d      = irq_en_q;
        start_d       = 1'b0;
        clr           = 2'b00;
        if (wr_en) begin
            case (idx)
                3'd0: begin
                    if (strb[0]) op_d = apb.pwdata[3:1];
                    start_d = start_req && !start_q;
                end
                3'd2: clr = apb.pwdata[1:0] & {2{strb[0]}};
                3'd3: if (strb[0]) irq_en_d = apb.pwdata[1:0];
                3'd4: begin
                    rows_d = (rows_q & ~wmask[7:0])  | (apb.pwdata[7:0]  & wmask[7:0]);
                    cols_d = (cols_q & ~wmask[15:8]) | (apb.pwdata[15:8] & wmask[15:8]);
                end
                default: ;
            endcase
        end
        done_sticky_d = (done_sticky_q && !start_d) || done_i;
        irq_stat_d    = (irq_stat_q & ~clr) | {err_i, done_i};
        irq_d         = |(irq_stat_q & irq_en_q);
    end

    // Read data mux; prdata is forced to 0 outside a clean read completion.
    always_comb begin
        rdata = '0;
        case (idx)
            3'd0: rdata[3:1]  = op_q;
            3'd1: rdata[1:0]  = {done_sticky_q, busy_i};
            3'd2: rdata[1:0]  = irq_stat_q;
            3'd3: rdata[1:0]  = irq_en_q;
            3'd4: rdata[15:0] = {cols_q, rows_q};
            3'd5: rdata       = ID_VALUE;
            default: ;
        endcase
        apb.prdata  = (pready && !apb.pwrite && !err) ? rdata : '0;
        apb.pready  = pready;
        apb.pslverr = pready && err;
    end

    // State and register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge here, so it lives inside the clocked branch.
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            start_q       <= 1'b0;
            op_q          <= '0;
            rows_q        <= '0;
            cols_q        <= '0;
            irq_en_q      <= '0;
            irq_stat_q    <= '0;
            done_sticky_q <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            start_q       <= start_d;
            op_q          <= op_d;
            rows_q        <= rows_d;
            cols_q        <= cols_d;
            irq_en_q      <= irq_en_d;
            irq_stat_q    <= irq_stat_d;
            done_sticky_q <= done_sticky_d;
            irq_q         <= irq_d;
        end
    end

    assign start_o = start_q;
    assign op_o    = op_q;
    assign rows_o  = rows_q;
    assign cols_o  = cols_q;
    assign irq_o   = irq_q;
endmodule

// File: tb/tb_alu_matrix_apb_regs.sv
// Bench for alu_matrix_apb_regs: one instance with WAIT_STATES=0 and one with 3.
// Expected APB responses are queued when a transfer is issued and compared when it completes.
module tb_alu_matrix_apb_regs;
    localparam logic [31:0] ID = 32'h00A1_0001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       busy_i, done_i, err_i;
    logic       start0, irq0, start3, irq3;
    logic [2:0] op0, op3;
    logic [7:0] rows0, cols0, rows3, cols3;

    alu_matrix_apb_regs_if #(.ADDR_W(12), .DATA_W(32)) apb0 ();
    alu_matrix_apb_regs_if #(.ADDR_W(12), .DATA_W(32)) apb3 ();

    alu_matrix_apb_regs #(.ADDR_W(12), .DATA_W(32), .WAIT_STATES(0), .ID_VALUE(ID)) dut0 (
        .clk(clk), .rst_n(rst_n), .apb(apb0),
        .start_o(start0), .op_o(op0), .rows_o(rows0), .cols_o(cols0),
        .busy_i(busy_i), .done_i(done_i), .err_i(err_i), .irq_o(irq0)
    );

    alu_matrix_apb_regs #(.ADDR_W(12), .DATA_W(32), .WAIT_STATES(3), .ID_VALUE(ID)) dut3 (
        .clk(clk), .rst_n(rst_n), .apb(apb3),
        .start_o(start3), .op_o(op3), .rows_o(rows3), .cols_o(cols3),
        .busy_i(1'b0), .done_i(1'b0), .err_i(1'b0), .irq_o(irq3)
    );

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    resp_t obs_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic set_bus(input bit sel3, input logic sel, input logic en, input logic wr,
                           input logic [11:0] a, input logic [31:0] d);
        apb0.psel    = sel & !sel3;
        apb3.psel    = sel & sel3;
        apb0.penable = en;      apb3.penable = en;
        apb0.pwrite  = wr;      apb3.pwrite  = wr;
        apb0.paddr   = a;       apb3.paddr   = a;
        apb0.pwdata  = d;       apb3.pwdata  = d;
    endtask

    // One APB transfer; the observed response goes to obs_q, ncyc = penable cycles to pready.
    task automatic apb_xfer(input bit sel3, input logic wr, input logic [11:0] a,
                            input logic [31:0] d, output int ncyc);
        resp_t r;
        bit    got;
        got  = 1'b0;
        ncyc = 0;
        @(posedge clk); #1;
        set_bus(sel3, 1'b1, 1'b0, wr, a, d);
        @(posedge clk); #1;
        set_bus(sel3, 1'b1, 1'b1, wr, a, d);
        for (int i = 0; i < 32 && !got; i++) begin
            @(negedge clk);
            ncyc++;
            if (sel3 ? apb3.pready : apb0.pready) begin
                r.name = "";
                r.data = sel3 ? apb3.prdata : apb0.prdata;
                r.err  = sel3 ? apb3.pslverr : apb0.pslverr;
                obs_q.push_back(r);
                got = 1'b1;
            end
            @(posedge clk); #1;
        end
        set_bus(sel3, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL xfer_timeout: addr=%h got no pready, required pready within 32 cycles", a);
            r.name = "";
            r.data = 'x;
            r.err  = 1'bx;
            obs_q.push_back(r);
        end
    endtask

    task automatic wr(input bit sel3, input logic [11:0] a, input logic [31:0] d,
                      input logic e_err, input string name, output int ncyc);
        resp_t e;
        e.name = name; e.data = 32'h0; e.err = e_err;
        exp_q.push_back(e);
        apb_xfer(sel3, 1'b1, a, d, ncyc);
    endtask

    task automatic rd(input bit sel3, input logic [11:0] a, input logic [31:0] e_data,
                      input logic e_err, input string name, output int ncyc);
        resp_t e;
        e.name = name; e.data = e_data; e.err = e_err;
        exp_q.push_back(e);
        apb_xfer(sel3, 1'b0, a, 32'h0, ncyc);
    endtask

    task automatic test_reset();
        resp_t e, o;
        int    n;
        rst_n  = 1'b0;
        busy_i = 1'b0; done_i = 1'b0; err_i = 1'b0;
        set_bus(1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({apb0.pready, apb0.pslverr, apb0.prdata} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got pready=%b pslverr=%b prdata=%h, required all 0",
                     apb0.pready, apb0.pslverr, apb0.prdata);
        end
        n_checks++;
        if ({start0, irq0, op0, rows0, cols0} !== 21'h0) begin
            n_fail++;
            $display("FAIL reset_core0: got start=%b irq=%b op=%h rows=%h cols=%h, required all 0",
                     start0, irq0, op0, rows0, cols0);
        end
        n_checks++;
        if ({start3, irq3, op3, rows3, cols3} !== 21'h0) begin
            n_fail++;
            $display("FAIL reset_core3: got start=%b irq=%b op=%h rows=%h cols=%h, required all 0",
                     start3, irq3, op3, rows3, cols3);
        end
        rd(1'b0, 12'h000, 32'h0, 1'b0, "reset_ctrl", n);
        n_checks++;
        if (n !== 1) begin
            n_fail++;
            $display("FAIL ws0_latency: got %0d penable cycles, required 1", n);
        end
        rd(1'b0, 12'h004, 32'h0, 1'b0, "reset_status", n);
        rd(1'b0, 12'h008, 32'h0, 1'b0, "reset_irq_stat", n);
        rd(1'b0, 12'h00C, 32'h0, 1'b0, "reset_irq_en", n);
        rd(1'b0, 12'h010, 32'h0, 1'b0, "reset_mat_size", n);
        rd(1'b0, 12'h014, ID, 1'b0, "reset_id", n);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o.data !== e.data || o.err !== e.err) begin
                n_fail++;
                $display("FAIL %s: got prdata=%h pslverr=%b, required prdata=%h pslverr=%b",
                         e.name, o.data, o.err, e.data, e.err);
            end
        end
    endtask

    task automatic test_mat_size();
        resp_t e, o;
        int    n;
        logic [15:0] v;
        wr(1'b0, 12'h010, 32'h0000_0403, 1'b0, "mat_wr", n);
        rd(1'b0, 12'h010, 32'h0000_0403, 1'b0, "mat_rd", n);
        n_checks++;
        if (rows0 !== 8'd3 || cols0 !== 8'd4) begin
            n_fail++;
            $display("FAIL mat_outputs: got rows=%0d cols=%0d, required rows=3 cols=4", rows0, cols0);
        end
        for (int i = 0; i < 4; i++) begin
            v = 16'($urandom);
            wr(1'b0, 12'h010, {16'($urandom), v}, 1'b0, "mat_pat_wr", n);
            rd(1'b0, 12'h010, {16'h0, v}, 1'b0, "mat_pat_rd", n);
        end
        wr(1'b0, 12'h010, 32'h0000_0403, 1'b0, "mat_restore", n);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o.data !== e.data || o.err !== e.err) begin
                n_fail++;
                $display("FAIL %s: got prdata=%h pslverr=%b, required prdata=%h pslverr=%b",
                         e.name, o.data, o.err, e.data, e.err);
            end
        end
    endtask

    task automatic test_start();
        resp_t e, o;
        int    n;
        busy_i = 1'b0;
        wr(1'b0, 12'h000, 32'h5, 1'b0, "start_wr", n);
        n_checks++;
        if (start0 !== 1'b1) begin
            n_fail++;
            $display("FAIL start_pulse: got start_o=%b after commit, required 1", start0);
        end
        @(posedge clk); #1;
        n_checks++;
        if (start0 !== 1'b0 || op0 !== 3'd2) begin
            n_fail++;
            $display("FAIL start_width: got start_o=%b op_o=%0d, required start_o=0 op_o=2", start0, op0);
        end
        rd(1'b0, 12'h000, 32'h4, 1'b0, "ctrl_rd", n);
        rd(1'b0, 12'h004, 32'h0, 1'b0, "status_idle", n);
        busy_i = 1'b1;
        wr(1'b0, 12'h000, 32'h7, 1'b1, "start_busy", n);
        n_checks++;
        if (start0 !== 1'b0) begin
            n_fail++;
            $display("FAIL start_busy_pulse: got start_o=%b, required 0", start0);
        end
        @(posedge clk); #1;
        n_checks++;
        if (start0 !== 1'b0 || op0 !== 3'd2) begin
            n_fail++;
            $display("FAIL start_busy_effect: got start_o=%b op_o=%0d, required start_o=0 op_o=2", start0, op0);
        end
        rd(1'b0, 12'h004, 32'h1, 1'b0, "status_busy", n);
        busy_i = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o.data !== e.data || o.err !== e.err) begin
                n_fail++;
                $display("FAIL %s: got prdata=%h pslverr=%b, required prdata=%h pslverr=%b",
                         e.name, o.data, o.err, e.data, e.err);
            end
        end
    endtask

    task automatic test_irq();
        resp_t e, o;
        int    n;
        wr(1'b0, 12'h00C, 32'h1, 1'b0, "irq_en_wr", n);
        @(posedge clk); #1 done_i = 1'b1;
        @(posedge clk); #1 done_i = 1'b0;
        n_checks++;
        if (irq0 !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_latency: got irq_o=%b in the status-set cycle, required 0", irq0);
        end
        @(posedge clk); #1;
        n_checks++;
        if (irq0 !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_assert: got irq_o=%b, required 1", irq0);
        end
        rd(1'b0, 12'h008, 32'h1, 1'b0, "irq_stat_done", n);
        rd(1'b0, 12'h004, 32'h2, 1'b0, "status_done_sticky", n);
        wr(1'b0, 12'h008, 32'h1, 1'b0, "irq_w1c", n);
        @(posedge clk); #1;
        n_checks++;
        if (irq0 !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_clear: got irq_o=%b, required 0", irq0);
        end
        fork
            wr(1'b0, 12'h008, 32'h1, 1'b0, "irq_w1c_collide", n);
            begin
                for (int i = 0; i < 32; i++) begin
                    @(negedge clk);
                    if (apb0.pready) begin
                        done_i = 1'b1;
                        @(posedge clk); #1;
                        done_i = 1'b0;
                        break;
                    end
                end
            end
        join
        rd(1'b0, 12'h008, 32'h1, 1'b0, "irq_set_wins", n);
        @(posedge clk); #1 err_i = 1'b1;
        @(posedge clk); #1 err_i = 1'b0;
        rd(1'b0, 12'h008, 32'h3, 1'b0, "irq_stat_both", n);
        wr(1'b0, 12'h008, 32'h3, 1'b0, "irq_w1c_both", n);
        rd(1'b0, 12'h008, 32'h0, 1'b0, "irq_stat_clear", n);
        n_checks++;
        if (irq0 !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_final: got irq_o=%b, required 0", irq0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o.data !== e.data || o.err !== e.err) begin
                n_fail++;
                $display("FAIL %s: got prdata=%h pslverr=%b, required prdata=%h pslverr=%b",
                         e.name, o.data, o.err, e.data, e.err);
            end
        end
    endtask

    task automatic test_errors();
        resp_t e, o;
        int    n;
        rd(1'b0, 12'h018, 32'h0, 1'b1, "err_unmapped_rd", n);
        rd(1'b0, 12'h002, 32'h0, 1'b1, "err_misaligned_rd", n);
        wr(1'b0, 12'h014, 32'h1234_5678, 1'b1, "err_id_wr", n);
        wr(1'b0, 12'h004, 32'hFFFF_FFFF, 1'b1, "err_status_wr", n);
        rd(1'b0, 12'h410, 32'h0, 1'b1, "err_upper_rd", n);
        wr(1'b0, 12'h012, 32'hFFFF_FFFF, 1'b1, "err_misaligned_wr", n);
        wr(1'b0, 12'h810, 32'hFFFF_FFFF, 1'b1, "err_upper_wr", n);
        wr(1'b0, 12'h00D, 32'h3, 1'b1, "err_irq_en_wr", n);
        rd(1'b0, 12'h010, 32'h0403, 1'b0, "err_mat_kept", n);
        rd(1'b0, 12'h00C, 32'h1, 1'b0, "err_irq_en_kept", n);
        rd(1'b0, 12'h014, ID, 1'b0, "err_id_kept", n);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o.data !== e.data || o.err !== e.err) begin
                n_fail++;
                $display("FAIL %s: got prdata=%h pslverr=%b, required prdata=%h pslverr=%b",
                         e.name, o.data, o.err, e.data, e.err);
            end
        end
    endtask

    task automatic test_wait_states();
        resp_t e, o;
        int    n;
        bit    seen;
        wr(1'b1, 12'h010, 32'h0000_0201, 1'b0, "ws3_wr", n);
        n_checks++;
        if (n !== 4) begin
            n_fail++;
            $display("FAIL ws3_latency: got pready on penable cycle %0d, required 4", n);
        end
        seen = 1'b0;
        @(posedge clk); #1;
        set_bus(1'b1, 1'b1, 1'b0, 1'b1, 12'h010, 32'h0000_AAAA);
        @(posedge clk); #1;
        set_bus(1'b1, 1'b1, 1'b1, 1'b1, 12'h010, 32'h0000_AAAA);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (apb3.pready) seen = 1'b1;
            @(posedge clk); #1;
        end
        set_bus(1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL ws3_abort_ready: got pready=1 during aborted access, required 0");
        end
        rd(1'b1, 12'h010, 32'h0000_0201, 1'b0, "ws3_abort_no_write", n);
        n_checks++;
        if (n !== 4 || rows3 !== 8'd1 || cols3 !== 8'd2 || op3 !== 3'd0 || start3 !== 1'b0 || irq3 !== 1'b0) begin
            n_fail++;
            $display("FAIL ws3_after_abort: got cycles=%0d rows=%0d cols=%0d op=%0d start=%b irq=%b, required 4 1 2 0 0 0",
                     n, rows3, cols3, op3, start3, irq3);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o.data !== e.data || o.err !== e.err) begin
                n_fail++;
                $display("FAIL %s: got prdata=%h pslverr=%b, required prdata=%h pslverr=%b",
                         e.name, o.data, o.err, e.data, e.err);
            end
        end
    endtask

`ifdef ALU_APB_PSTRB_EN
    initial begin
        apb0.pstrb = 4'hF;
        apb3.pstrb = 4'hF;
    end

    task automatic test_pstrb();
        resp_t e, o;
        int    n;
        apb0.pstrb = 4'hF;
        wr(1'b0, 12'h010, 32'h0000_0403, 1'b0, "pstrb_full_wr", n);
        apb0.pstrb = 4'b0010;
        wr(1'b0, 12'h010, 32'hFFFF_FFFF, 1'b0, "pstrb_byte1_wr", n);
        wr(1'b0, 12'h000, 32'h0000_0001, 1'b0, "pstrb_start_masked", n);
        n_checks++;
        if (start0 !== 1'b0) begin
            n_fail++;
            $display("FAIL pstrb_start: got start_o=%b with pstrb[0]=0, required 0", start0);
        end
        apb0.pstrb = 4'hF;
        rd(1'b0, 12'h010, 32'h0000_FF03, 1'b0, "pstrb_rd", n);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o.data !== e.data || o.err !== e.err) begin
                n_fail++;
                $display("FAIL %s: got prdata=%h pslverr=%b, required prdata=%h pslverr=%b",
                         e.name, o.data, o.err, e.data, e.err);
            end
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_mat_size();
        test_start();
        test_irq();
        test_errors();
        test_wait_states();
`ifdef ALU_APB_PSTRB_EN
        test_pstrb();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
